// File: rtl/inst_fetch_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inst_fetch_responder_pkg                                             |
// | Shared fetch constants and FSM state encoding.                       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package inst_fetch_responder_pkg;

  localparam int WORD_BYTES         = 4;
  localparam int LINE_BYTES_DEFAULT = 32;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_REQ1  = 3'd1;
  localparam state_t ST_WAIT1 = 3'd2;
  localparam state_t ST_REQ2  = 3'd3;
  localparam state_t ST_WAIT2 = 3'd4;
  localparam state_t ST_RESP  = 3'd5;

endpackage
`default_nettype wire

// File: rtl/inst_fetch_responder_line_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inst_fetch_responder_line_edge                                       |
// | Flags whether the word after i_addr lies in the same fetch line.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module inst_fetch_responder_line_edge #(
  parameter int LINE_BYTES = 32
) (
  input  logic [31:0] i_addr,
  output logic        o_need2
);

  localparam int OFF_W = $clog2(LINE_BYTES);

  logic [OFF_W-3:0] w_word_idx;
  logic             w_unused;

  assign w_word_idx = i_addr[OFF_W-1:2];
  // Last word of the line: addr+4 would cross into the next line.
  assign o_need2    = ~(&w_word_idx);
  assign w_unused   = ^{i_addr[31:OFF_W], i_addr[1:0]};

endmodule
`default_nettype wire

// File: rtl/inst_fetch_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inst_fetch_responder                                                 |
// | Dual-word instruction fetch responder over an sram-like memory bus.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module inst_fetch_responder
  import inst_fetch_responder_pkg::*;
#(
  parameter int LINE_BYTES = LINE_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        sram_inst_ena,
  input  logic [31:0] sram_inst_addr,
  output logic [31:0] sram_inst_rdata_1,
  output logic [31:0] sram_inst_rdata_2,
  output logic        sram_inst_ok_1,
  output logic        sram_inst_ok_2,
  output logic        fetch_busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_base;
  logic        r_need2;
  logic        r_cancel;
  logic [31:0] r_rdata_1;
  logic [31:0] r_rdata_2;
  logic        r_ok_1;
  logic        r_ok_2;

  logic        w_need2;
  logic        w_accept;
  logic        w_drop;
  logic        w_in_req;
  logic        w_in_wait;
  logic        w_cap1;
  logic        w_cap2;

  inst_fetch_responder_line_edge #(
    .LINE_BYTES (LINE_BYTES)
  ) u_line_edge (
    .i_addr  (sram_inst_addr),
    .o_need2 (w_need2)
  );

  assign w_accept  = (r_state == ST_IDLE) && sram_inst_ena && !flush;
  // A response already in flight when flush arrives must still be drained.
  assign w_drop    = flush || r_cancel;
  assign w_in_req  = (r_state == ST_REQ1) || (r_state == ST_REQ2);
  assign w_in_wait = (r_state == ST_WAIT1) || (r_state == ST_WAIT2);
  assign w_cap1    = (r_state == ST_WAIT1) && mem_data_ok && !w_drop;
  assign w_cap2    = (r_state == ST_WAIT2) && mem_data_ok && !w_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = ST_REQ1;
      end
      ST_REQ1: begin
        if (mem_addr_ok)  w_next = ST_WAIT1;
        else if (flush)   w_next = ST_IDLE;
      end
      ST_WAIT1: begin
        if (mem_data_ok) begin
          if (w_drop)       w_next = ST_IDLE;
          else if (r_need2) w_next = ST_REQ2;
          else              w_next = ST_RESP;
        end
      end
      ST_REQ2: begin
        if (mem_addr_ok)  w_next = ST_WAIT2;
        else if (flush)   w_next = ST_IDLE;
      end
      ST_WAIT2: begin
        if (mem_data_ok) w_next = w_drop ? ST_IDLE : ST_RESP;
      end
      ST_RESP: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    mem_req    = w_in_req;
    mem_addr   = 32'd0;
    fetch_busy = (r_state != ST_IDLE);
    if (r_state == ST_REQ1) mem_addr = r_base;
    if (r_state == ST_REQ2) mem_addr = r_base + 32'(WORD_BYTES);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base    <= 32'd0;
      r_need2   <= 1'b0;
      r_cancel  <= 1'b0;
      r_rdata_1 <= 32'd0;
      r_rdata_2 <= 32'd0;
      r_ok_1    <= 1'b0;
      r_ok_2    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_base  <= {sram_inst_addr[31:2], 2'b00};
        r_need2 <= w_need2;
      end
      if (w_in_req && flush && mem_addr_ok) begin
        r_cancel <= 1'b1;
      end else if (w_in_wait) begin
        if (mem_data_ok)  r_cancel <= 1'b0;
        else if (flush)   r_cancel <= 1'b1;
      end
      if (w_cap1) r_rdata_1 <= mem_rdata;
      if (w_cap2) r_rdata_2 <= mem_rdata;
      r_ok_1 <= (r_state == ST_RESP) && !flush;
      r_ok_2 <= (r_state == ST_RESP) && !flush && r_need2;
    end
  end

  assign sram_inst_rdata_1 = r_rdata_1;
  assign sram_inst_rdata_2 = r_rdata_2;
  assign sram_inst_ok_1    = r_ok_1;
  assign sram_inst_ok_2    = r_ok_2;

  // Read data with no outstanding transaction is a memory-side protocol error.
  always_ff @(posedge clk) begin
    if (!rst && mem_data_ok) begin
      assert (w_in_wait)
        else $error("inst_fetch_responder: data_ok outside WAIT state");
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_inst_fetch_responder                                              |
// | Directed cycle-accurate bench for inst_fetch_responder.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_inst_fetch_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        sram_inst_ena;
  logic [31:0] sram_inst_addr;
  logic [31:0] sram_inst_rdata_1;
  logic [31:0] sram_inst_rdata_2;
  logic        sram_inst_ok_1;
  logic        sram_inst_ok_2;
  logic        fetch_busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] e_r1;
  logic [31:0] e_r2;

  inst_fetch_responder #(.LINE_BYTES(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .sram_inst_ena     (sram_inst_ena),
    .sram_inst_addr    (sram_inst_addr),
    .sram_inst_rdata_1 (sram_inst_rdata_1),
    .sram_inst_rdata_2 (sram_inst_rdata_2),
    .sram_inst_ok_1    (sram_inst_ok_1),
    .sram_inst_ok_2    (sram_inst_ok_2),
    .fetch_busy        (fetch_busy),
    .mem_req           (mem_req),
    .mem_addr          (mem_addr),
    .mem_addr_ok       (mem_addr_ok),
    .mem_data_ok       (mem_data_ok),
    .mem_rdata         (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
  endtask

  task automatic start(input logic [31:0] a);
    sram_inst_addr = a;
    sram_inst_ena  = 1'b1;
    tick();
    sram_inst_ena  = 1'b0;
  endtask

  // Holds addr_ok low for 'stall' cycles, then accepts; mem_req/mem_addr must be stable throughout.
  task automatic handshake(input string tag, input logic [31:0] a, input int stall);
    for (int i = 0; i < stall; i++) begin
      chkb({tag, "_req_stall"}, mem_req, 1'b1);
      chk({tag, "_addr_stall"}, mem_addr, a);
      tick();
    end
    chkb({tag, "_req"}, mem_req, 1'b1);
    chk({tag, "_addr"}, mem_addr, a);
    mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0;
  endtask

  task automatic give_data(input string tag, input logic [31:0] d);
    chkb({tag, "_noreq_wait"}, mem_req, 1'b0);
    mem_data_ok = 1'b1;
    mem_rdata   = d;
    tick();
    mem_data_ok = 1'b0;
  endtask

  task automatic finish_resp(input string tag, input logic exp2);
    chkb({tag, "_ok1_pre"}, sram_inst_ok_1, 1'b0);
    chkb({tag, "_noreq_resp"}, mem_req, 1'b0);
    tick();
    chkb({tag, "_ok1"}, sram_inst_ok_1, 1'b1);
    chkb({tag, "_ok2"}, sram_inst_ok_2, exp2);
    chk({tag, "_rdata1"}, sram_inst_rdata_1, e_r1);
    chk({tag, "_rdata2"}, sram_inst_rdata_2, e_r2);
    chkb({tag, "_busy"}, fetch_busy, 1'b0);
    tick();
    chkb({tag, "_ok1_post"}, sram_inst_ok_1, 1'b0);
    chkb({tag, "_ok2_post"}, sram_inst_ok_2, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; sram_inst_ena = 1'b0; sram_inst_addr = 32'd0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;
    e_r1 = 32'd0; e_r2 = 32'd0;
    tick(); tick();
    rst = 1'b0;
    chkb("rst_ok1", sram_inst_ok_1, 1'b0);
    chkb("rst_ok2", sram_inst_ok_2, 1'b0);
    chk("rst_rdata1", sram_inst_rdata_1, 32'd0);
    chk("rst_rdata2", sram_inst_rdata_2, 32'd0);
    chkb("rst_req", mem_req, 1'b0);
    chk("rst_addr", mem_addr, 32'd0);
    chkb("rst_busy", fetch_busy, 1'b0);

    // Two-word zero-wait fetch: ok six cycles after ena.
    start(32'h1FC0_0000);
    chkb("t1_busy", fetch_busy, 1'b1);
    handshake("t1_w1", 32'h1FC0_0000, 0);
    give_data("t1_w1", 32'h3C08_BFC0);
    handshake("t1_w2", 32'h1FC0_0004, 0);
    give_data("t1_w2", 32'h3508_FFFF);
    e_r1 = 32'h3C08_BFC0; e_r2 = 32'h3508_FFFF;
    finish_resp("t1", 1'b1);

    // Last word of the line: single request, rdata_2 keeps its old value.
    start(32'hBFC0_001C);
    handshake("t2", 32'hBFC0_001C, 0);
    give_data("t2", 32'h1111_1111);
    e_r1 = 32'h1111_1111;
    finish_resp("t2", 1'b0);

    // Three stall cycles on the first request; low address bits ignored.
    start(32'h0000_0043);
    handshake("t3_w1", 32'h0000_0040, 3);
    give_data("t3_w1", 32'hAAAA_0001);
    handshake("t3_w2", 32'h0000_0044, 0);
    give_data("t3_w2", 32'hAAAA_0002);
    e_r1 = 32'hAAAA_0001; e_r2 = 32'hAAAA_0002;
    finish_resp("t3", 1'b1);

    // Flush while waiting on word 1; late data must be drained and discarded.
    start(32'h0000_0080);
    handshake("t4", 32'h0000_0080, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chkb("t4_busy_drain", fetch_busy, 1'b1);
    chkb("t4_noreq_drain", mem_req, 1'b0);
    mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_data_ok = 1'b0;
    chkb("t4_busy_fall", fetch_busy, 1'b0);
    chkb("t4_ok1", sram_inst_ok_1, 1'b0);
    chk("t4_rdata1", sram_inst_rdata_1, e_r1);
    tick();
    chkb("t4_noreq2", mem_req, 1'b0);
    chkb("t4_ok1_late", sram_inst_ok_1, 1'b0);

    // Flush in REQ2 before acceptance, then a normal fetch.
    start(32'h0000_00C0);
    handshake("t5_w1", 32'h0000_00C0, 0);
    give_data("t5_w1", 32'h2222_2222);
    e_r1 = 32'h2222_2222;
    chkb("t5_req2", mem_req, 1'b1);
    chk("t5_addr2", mem_addr, 32'h0000_00C4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chkb("t5_req_drop", mem_req, 1'b0);
    chkb("t5_idle", fetch_busy, 1'b0);
    chkb("t5_ok1", sram_inst_ok_1, 1'b0);
    start(32'h0000_0100);
    handshake("t5b_w1", 32'h0000_0100, 0);
    give_data("t5b_w1", 32'h0100_0001);
    handshake("t5b_w2", 32'h0000_0104, 0);
    give_data("t5b_w2", 32'h0100_0002);
    e_r1 = 32'h0100_0001; e_r2 = 32'h0100_0002;
    finish_resp("t5b", 1'b1);

    // Flush in IDLE masks ena.
    flush = 1'b1; sram_inst_ena = 1'b1; sram_inst_addr = 32'h0000_0200;
    tick();
    flush = 1'b0; sram_inst_ena = 1'b0;
    chkb("t6_busy", fetch_busy, 1'b0);
    chkb("t6_req", mem_req, 1'b0);

    // Flush in RESP suppresses the ok pulse.
    start(32'h0000_001C);
    handshake("t7", 32'h0000_001C, 0);
    give_data("t7", 32'h3333_3333);
    e_r1 = 32'h3333_3333;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chkb("t7_ok1", sram_inst_ok_1, 1'b0);
    chkb("t7_ok2", sram_inst_ok_2, 1'b0);
    chkb("t7_busy", fetch_busy, 1'b0);
    chk("t7_rdata1", sram_inst_rdata_1, e_r1);

    // Flush coincident with addr_ok in REQ1: transaction issued, response discarded.
    start(32'h0000_0300);
    chkb("t8_req", mem_req, 1'b1);
    flush = 1'b1; mem_addr_ok = 1'b1;
    tick();
    flush = 1'b0; mem_addr_ok = 1'b0;
    chkb("t8_busy", fetch_busy, 1'b1);
    mem_data_ok = 1'b1; mem_rdata = 32'h4444_4444;
    tick();
    mem_data_ok = 1'b0;
    chkb("t8_idle", fetch_busy, 1'b0);
    chk("t8_rdata1", sram_inst_rdata_1, e_r1);
    tick();
    chkb("t8_ok1", sram_inst_ok_1, 1'b0);
    chkb("t8_noreq", mem_req, 1'b0);

    // Reset in WAIT2 clears everything; data_ok under reset is ignored.
    start(32'h0000_0400);
    handshake("t9_w1", 32'h0000_0400, 0);
    give_data("t9_w1", 32'h5555_5555);
    handshake("t9_w2", 32'h0000_0404, 0);
    rst = 1'b1;
    tick();
    chkb("t9_ok1", sram_inst_ok_1, 1'b0);
    chkb("t9_ok2", sram_inst_ok_2, 1'b0);
    chk("t9_rdata1", sram_inst_rdata_1, 32'd0);
    chk("t9_rdata2", sram_inst_rdata_2, 32'd0);
    chkb("t9_req", mem_req, 1'b0);
    chk("t9_addr", mem_addr, 32'd0);
    chkb("t9_busy", fetch_busy, 1'b0);
    mem_data_ok = 1'b1; mem_rdata = 32'h6666_6666;
    tick();
    rst = 1'b0; mem_data_ok = 1'b0;
    chk("t9_rdata1_stray", sram_inst_rdata_1, 32'd0);
    chkb("t9_busy_stray", fetch_busy, 1'b0);
    tick();
    chkb("t9_ok1_stray", sram_inst_ok_1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
